// File: rtl/game_id_loader.sv
// game_id_loader: captures the 4-byte board-identity header from the ioctl
// download bus. It validates the header, commits the game code and holds the
// core in reset while a configuration download is in flight.
module game_id_loader #(
    parameter logic [7:0] CFG_INDEX  = 8'd1,
    parameter int         GAME_W     = 8,
    parameter logic [7:0] GAME_COUNT = 8'd16,
    parameter logic [7:0] MAGIC0     = 8'h54,
    parameter logic [7:0] MAGIC1     = 8'h46
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [26:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [GAME_W-1:0] game,
    output logic              game_valid,
    output logic              game_changed,
    output logic              cfg_error,
    output logic              core_reset_req
);

    typedef enum logic [1:0] {IDLE, RECEIVE, VALIDATE, COMMIT} state_t;

    state_t            state_reg, state_next;
    logic              cfg_active;
    logic              cfg_active_q;
    logic              cfg_start;
    logic              header_wr;
    logic [3:0]        addr_onehot;
    logic              capture_en;
    logic              header_pass;
    logic [3:0]        mask_reg, mask_next;
    logic [7:0]        slot_reg [4];
    logic [GAME_W-1:0] game_reg, game_next;
    logic              valid_reg, valid_next;
    logic              changed_reg, changed_next;
    logic              error_reg, error_next;
    logic              core_rst_reg, core_rst_next;

    // The config stream is one specific download index; every other index is invisible here.
    assign cfg_active  = ioctl_download && (ioctl_index == CFG_INDEX);
    assign cfg_start   = cfg_active && !cfg_active_q;
    assign header_wr   = ioctl_wr && cfg_active && (ioctl_addr[26:2] == 25'd0);
    assign addr_onehot = 4'b0001 << ioctl_addr[1:0];

    assign header_pass = (mask_reg == 4'hF)
                      && (slot_reg[0] == MAGIC0)
                      && (slot_reg[1] == MAGIC1)
                      && (slot_reg[3] == ~slot_reg[2])
                      && (slot_reg[2] < GAME_COUNT);

    // Stream-edge history. It resets high, so a download already in flight when
    // reset releases is not mistaken for a fresh start. The header is only
    // re-read after the stream has been seen inactive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_active_q <= 1'b1;
        end else begin
            cfg_active_q <= cfg_active;
        end
    end

    // Header byte slots; each slot captures its own address when capture is enabled.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            // Slot gi register: last write to address gi wins.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    slot_reg[gi] <= 8'd0;
                end else if (capture_en && (ioctl_addr[1:0] == 2'(gi))) begin
                    slot_reg[gi] <= ioctl_dout;
                end
            end
        end
    endgenerate

    // FSM state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            mask_reg     <= 4'd0;
            game_reg     <= '0;
            valid_reg    <= 1'b0;
            changed_reg  <= 1'b0;
            error_reg    <= 1'b0;
            core_rst_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            mask_reg     <= mask_next;
            game_reg     <= game_next;
            valid_reg    <= valid_next;
            changed_reg  <= changed_next;
            error_reg    <= error_next;
            core_rst_reg <= core_rst_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next    = state_reg;
        mask_next     = mask_reg;
        capture_en    = 1'b0;
        game_next     = game_reg;
        valid_next    = valid_reg;
        changed_next  = 1'b0;
        error_next    = error_reg;
        core_rst_next = core_rst_reg;

        case (state_reg)
            IDLE: begin
                // Leaving IDLE is handled by the restart logic below.
            end
            RECEIVE: begin
                if (!cfg_active) begin
                    // Stream ended. A write in this same cycle is not part of the stream.
                    state_next = VALIDATE;
                end else if (header_wr) begin
                    capture_en = 1'b1;
                    mask_next  = mask_reg | addr_onehot;
                end
            end
            VALIDATE: begin
                if (header_pass) begin
                    // Loading the game code here makes it and the change pulse
                    // visible during the COMMIT cycle.
                    state_next   = COMMIT;
                    game_next    = slot_reg[2][GAME_W-1:0];
                    valid_next   = 1'b1;
                    changed_next = 1'b1;
                end else begin
                    state_next = IDLE;
                    error_next = 1'b1;
                    // If a good board was already running, keep it running.
                    if (valid_reg) begin
                        core_rst_next = 1'b0;
                    end
                end
            end
            COMMIT: begin
                state_next    = IDLE;
                core_rst_next = 1'b0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A fresh config download restarts capture from any state except RECEIVE.
        // In COMMIT the new code is already registered, so the commit still completes.
        if (cfg_start && (state_reg != RECEIVE)) begin
            state_next    = RECEIVE;
            error_next    = 1'b0;
            core_rst_next = 1'b1;
            capture_en    = header_wr;
            mask_next     = header_wr ? addr_onehot : 4'd0;
            game_next     = game_reg;
            valid_next    = valid_reg;
            changed_next  = 1'b0;
        end
    end

    assign game           = game_reg;
    assign game_valid     = valid_reg;
    assign game_changed   = changed_reg;
    assign cfg_error      = error_reg;
    assign core_reset_req = core_rst_reg;

endmodule

// File: tb/tb_game_id_loader.sv
// tb_game_id_loader: table-driven header vectors plus hand-written sequences
// for payload/index filtering, asynchronous reset mid-capture and restart during COMMIT.
module tb_game_id_loader;

    logic        clk;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  game;
    logic        game_valid;
    logic        game_changed;
    logic        cfg_error;
    logic        core_reset_req;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b0, b1, b2, b3;
        logic [3:0] mask;
        logic       pass;
        logic [7:0] exp_game;
        logic       exp_valid;
        logic       exp_err;
        logic       exp_rst;
    } vec_t;

    vec_t vecs [8];

    game_id_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .game           (game),
        .game_valid     (game_valid),
        .game_changed   (game_changed),
        .cfg_error      (cfg_error),
        .core_reset_req (core_reset_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [26:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        step();
        ioctl_wr    = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        step();
    endtask

    task automatic run_vec(input int n);
        logic [7:0] hb [4];
        vec_t v;
        v = vecs[n];
        hb[0] = v.b0; hb[1] = v.b1; hb[2] = v.b2; hb[3] = v.b3;
        start_dl(8'd1);
        check($sformatf("v%0d_err_clear", n), 32'(cfg_error), 32'd0);
        check($sformatf("v%0d_rst_hold", n), 32'(core_reset_req), 32'd1);
        for (int a = 0; a < 4; a++) begin
            if (v.mask[a]) wr_byte(8'd1, 27'(a), hb[a]);
        end
        ioctl_download = 1'b0;
        step();
        check($sformatf("v%0d_k1_changed", n), 32'(game_changed), 32'd0);
        check($sformatf("v%0d_k1_rst", n), 32'(core_reset_req), 32'd1);
        step();
        check($sformatf("v%0d_k2_changed", n), 32'(game_changed), 32'(v.pass));
        check($sformatf("v%0d_k2_err", n), 32'(cfg_error), 32'(v.exp_err));
        if (v.pass) check($sformatf("v%0d_k2_game", n), 32'(game), 32'(v.exp_game));
        step();
        check($sformatf("v%0d_k3_changed", n), 32'(game_changed), 32'd0);
        check($sformatf("v%0d_rst", n), 32'(core_reset_req), 32'(v.exp_rst));
        check($sformatf("v%0d_game", n), 32'(game), 32'(v.exp_game));
        check($sformatf("v%0d_valid", n), 32'(game_valid), 32'(v.exp_valid));
        check($sformatf("v%0d_err", n), 32'(cfg_error), 32'(v.exp_err));
        $display("vec %0d hdr %h %h %h %h mask %h -> game=%0d valid=%0d err=%0d rst=%0d",
                 n, v.b0, v.b1, v.b2, v.b3, v.mask, game, game_valid, cfg_error, core_reset_req);
        step();
    endtask

    initial begin
        logic seen_pulse;

        //           b0     b1     b2     b3     mask  pass  game  val   err   rst
        vecs[0] = '{8'h54, 8'h46, 8'h03, 8'hFD, 4'hF, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{8'h54, 8'h46, 8'h03, 8'hFC, 4'hF, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h54, 8'h46, 8'h02, 8'hFD, 4'hF, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 8'h46, 8'h02, 8'hFD, 4'hF, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h54, 8'h46, 8'h07, 8'hF8, 4'hB, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h54, 8'h46, 8'h10, 8'hEF, 4'hF, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h54, 8'h46, 8'h0F, 8'hF0, 4'hF, 1'b1, 8'd15, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h54, 8'h46, 8'h00, 8'hFF, 4'hF, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0};

        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 27'd0;
        ioctl_dout     = 8'd0;
        step();
        step();
        check("reset_game", 32'(game), 32'd0);
        check("reset_valid", 32'(game_valid), 32'd0);
        check("reset_changed", 32'(game_changed), 32'd0);
        check("reset_err", 32'(cfg_error), 32'd0);
        check("reset_rst", 32'(core_reset_req), 32'd1);
        reset_n = 1'b1;
        step();
        step();

        for (int n = 0; n < 8; n++) run_vec(n);

        // Index-0 download carrying a valid-looking header: must be ignored.
        start_dl(8'd0);
        wr_byte(8'd0, 27'd0, 8'h54);
        wr_byte(8'd0, 27'd1, 8'h46);
        wr_byte(8'd0, 27'd2, 8'h09);
        wr_byte(8'd0, 27'd3, 8'hF6);
        ioctl_download = 1'b0;
        seen_pulse = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (game_changed) seen_pulse = 1'b1;
        end
        check("idx0_game", 32'(game), 32'd0);
        check("idx0_pulse", 32'(seen_pulse), 32'd0);
        check("idx0_rst", 32'(core_reset_req), 32'd0);
        $display("index-0 download -> game=%0d rst=%0d", game, core_reset_req);

        // Config download with 1000 payload bytes and interleaved header writes.
        start_dl(8'd1);
        for (int i = 0; i < 1000; i++) begin
            if (i == 100) wr_byte(8'd1, 27'd0, 8'h54);
            if (i == 200) wr_byte(8'd1, 27'd2, 8'h09);
            if (i == 300) wr_byte(8'd1, 27'd1, 8'h46);
            if (i == 500) wr_byte(8'd1, 27'd2, 8'h05);
            if (i == 700) wr_byte(8'd1, 27'd3, 8'hFA);
            wr_byte(8'd1, 27'(4 + i), 8'hA5 ^ 8'(i));
        end
        ioctl_download = 1'b0;
        step();
        step();
        check("payload_changed", 32'(game_changed), 32'd1);
        step();
        check("payload_game", 32'(game), 32'd5);
        check("payload_valid", 32'(game_valid), 32'd1);
        check("payload_err", 32'(cfg_error), 32'd0);
        check("payload_rst", 32'(core_reset_req), 32'd0);
        $display("payload download -> game=%0d err=%0d rst=%0d", game, cfg_error, core_reset_req);
        step();

        // Asynchronous reset in the middle of header capture.
        start_dl(8'd1);
        wr_byte(8'd1, 27'd0, 8'h54);
        wr_byte(8'd1, 27'd1, 8'h46);
        #2 reset_n = 1'b0;
        #1;
        check("amid_game", 32'(game), 32'd0);
        check("amid_valid", 32'(game_valid), 32'd0);
        check("amid_err", 32'(cfg_error), 32'd0);
        check("amid_rst", 32'(core_reset_req), 32'd1);
        step();
        reset_n = 1'b1;
        step();
        wr_byte(8'd1, 27'd2, 8'h02);
        wr_byte(8'd1, 27'd3, 8'hFD);
        ioctl_download = 1'b0;
        seen_pulse = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (game_changed) seen_pulse = 1'b1;
        end
        check("areset_pulse", 32'(seen_pulse), 32'd0);
        check("areset_valid", 32'(game_valid), 32'd0);
        check("areset_err", 32'(cfg_error), 32'd0);
        check("areset_rst", 32'(core_reset_req), 32'd1);
        $display("reset mid-receive -> valid=%0d err=%0d rst=%0d", game_valid, cfg_error, core_reset_req);

        // New download starting during the COMMIT cycle.
        start_dl(8'd1);
        wr_byte(8'd1, 27'd0, 8'h54);
        wr_byte(8'd1, 27'd1, 8'h46);
        wr_byte(8'd1, 27'd2, 8'h01);
        wr_byte(8'd1, 27'd3, 8'hFE);
        ioctl_download = 1'b0;
        step();
        step();
        check("restart_changed", 32'(game_changed), 32'd1);
        check("restart_game1", 32'(game), 32'd1);
        ioctl_download = 1'b1;
        step();
        check("restart_rst_hold", 32'(core_reset_req), 32'd1);
        check("restart_valid", 32'(game_valid), 32'd1);
        wr_byte(8'd1, 27'd0, 8'h54);
        wr_byte(8'd1, 27'd1, 8'h46);
        wr_byte(8'd1, 27'd2, 8'h04);
        wr_byte(8'd1, 27'd3, 8'hFB);
        ioctl_download = 1'b0;
        step();
        step();
        step();
        check("restart_game4", 32'(game), 32'd4);
        check("restart_rst", 32'(core_reset_req), 32'd0);
        check("restart_err", 32'(cfg_error), 32'd0);
        $display("restart at commit -> game=%0d rst=%0d", game, core_reset_req);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
